// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side UART frame controller: oversampled start/data/parity/stop sequencing,
// parity-checker word assembly with fault arming, and per-byte status reporting.
module uart_rx_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_even_parity,
  input  logic                  inject_parity_fault,
  output logic [DATA_WIDTH:0]   chk_data,
  output logic                  chk_even_parity,
  output logic                  chk_fault_inject,
  input  logic                  chk_parity_err,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] HalfCnt = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StCheck,
    StBreak
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_en_q, parity_en_d;
  logic                  even_q, even_d;
  logic                  fault_armed_q, fault_armed_d;
  logic [DATA_WIDTH:0]   chk_data_q, chk_data_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_ferr_q, rx_ferr_d;
  logic [DATA_WIDTH:0]   shift_in;

  // LSB-first: new bit enters at the top and the word drifts down.
  assign shift_in = {rx, shift_q};

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    frame_err_d   = frame_err_q;
    parity_en_d   = parity_en_q;
    even_d        = even_q;
    fault_armed_d = fault_armed_q;
    chk_data_d    = chk_data_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_perr_d     = rx_perr_q;
    rx_ferr_d     = rx_ferr_q;

    // A new request wins over consumption so a pulse during CHECK survives.
    if (state_q == StCheck && parity_en_q) fault_armed_d = 1'b0;
    if (inject_parity_fault) fault_armed_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (baud_tick && !rx) begin
          state_d     = StStart;
          tick_cnt_d  = '0;
          parity_en_d = cfg_parity_en;
          even_d      = cfg_even_parity;
          par_bit_d   = 1'b0;
        end
      end
      StStart: begin
        if (baud_tick) begin
          if (tick_cnt_q == HalfCnt) begin
            tick_cnt_d = '0;
            if (rx) begin
              state_d = StIdle;
            end else begin
              bit_idx_d = '0;
              state_d   = StData;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (baud_tick) begin
          if (tick_cnt_q == FullCnt) begin
            tick_cnt_d = '0;
            shift_d    = shift_in[DATA_WIDTH:1];
            if (bit_idx_q == LastIdx) begin
              bit_idx_d = '0;
              state_d   = parity_en_q ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + IdxW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          if (tick_cnt_q == FullCnt) begin
            tick_cnt_d = '0;
            par_bit_d  = rx;
            state_d    = StStop;
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (baud_tick) begin
          if (tick_cnt_q == FullCnt) begin
            tick_cnt_d  = '0;
            frame_err_d = !rx;
            chk_data_d  = {parity_en_q & par_bit_q, shift_q};
            state_d     = StCheck;
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
      end
      StCheck: begin
        rx_valid_d = 1'b1;
        rx_data_d  = chk_data_q[DATA_WIDTH-1:0];
        rx_perr_d  = chk_parity_err & parity_en_q;
        rx_ferr_d  = frame_err_q;
        state_d    = frame_err_q ? StBreak : StIdle;
      end
      StBreak: begin
        // Wait for the line to recover so a held-low rx cannot fake a start.
        if (baud_tick && rx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tick_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_bit_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_en_q   <= 1'b0;
      even_q        <= 1'b0;
      fault_armed_q <= 1'b0;
      chk_data_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      frame_err_q   <= frame_err_d;
      parity_en_q   <= parity_en_d;
      even_q        <= even_d;
      fault_armed_q <= fault_armed_d;
      chk_data_q    <= chk_data_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign chk_data         = chk_data_q;
  assign chk_even_parity  = even_q;
  assign chk_fault_inject = fault_armed_q & (state_q == StCheck) & parity_en_q;
  assign rx_data          = rx_data_q;
  assign rx_valid         = rx_valid_q;
  assign rx_parity_err    = rx_perr_q;
  assign rx_frame_err     = rx_ferr_q;
  assign busy             = (state_q != StIdle) && (state_q != StBreak);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a behavioural parity checker stand-in.
module tb_uart_rx_frame_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, baud_tick, rx, cfg_parity_en, cfg_even_parity, inject_parity_fault;
  logic [DW:0]   chk_data;
  logic          chk_even_parity, chk_fault_inject, chk_parity_err;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_parity_err, rx_frame_err, busy;

  int n_checks = 0;
  int n_fails = 0;
  int valid_pulses = 0;

  logic          obs_v0, obs_v1, obs_v2, obs_fi0, obs_fi1, obs_perr, obs_ferr;
  logic [DW-1:0] obs_data;
  logic [DW:0]   obs_chk;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .baud_tick           (baud_tick),
    .rx                  (rx),
    .cfg_parity_en       (cfg_parity_en),
    .cfg_even_parity     (cfg_even_parity),
    .inject_parity_fault (inject_parity_fault),
    .chk_data            (chk_data),
    .chk_even_parity     (chk_even_parity),
    .chk_fault_inject    (chk_fault_inject),
    .chk_parity_err      (chk_parity_err),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_parity_err       (rx_parity_err),
    .rx_frame_err        (rx_frame_err),
    .busy                (busy)
  );

  always #10 clk = ~clk;

  // Checker model: error when the 9-bit word's parity disagrees; injection inverts it.
  assign chk_parity_err = (chk_even_parity ? (^chk_data) : ~(^chk_data)) ^ chk_fault_inject;

  always @(posedge clk) if (rx_valid === 1'b1) valid_pulses++;

  task automatic tick_rx(input logic b);
    @(negedge clk);
    rx = b;
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  task automatic pulse_inject();
    @(negedge clk);
    inject_parity_fault = 1'b1;
    @(negedge clk);
    inject_parity_fault = 1'b0;
  endtask

  // Drives a whole frame, one bit per 16 ticks; captures outputs around the stop sample.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                            input logic stop);
    int   nbits;
    int   stop_k;
    int   bi;
    logic b;
    nbits  = pen ? 11 : 10;
    stop_k = 8 + 16 * (nbits - 1);
    for (int k = 0; k < 16 * nbits; k++) begin
      bi = k / 16;
      if (bi == 0) b = 1'b0;
      else if (bi <= DW) b = d[bi-1];
      else if (pen && bi == DW + 1) b = pbit;
      else b = stop;
      tick_rx(b);
      if (k == stop_k) begin
        obs_v0  = rx_valid;
        obs_fi0 = chk_fault_inject;
        obs_chk = chk_data;
        @(negedge clk);
        obs_v1   = rx_valid;
        obs_fi1  = chk_fault_inject;
        obs_data = rx_data;
        obs_perr = rx_parity_err;
        obs_ferr = rx_frame_err;
        @(negedge clk);
        obs_v2 = rx_valid;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({chk_data, chk_even_parity, chk_fault_inject, rx_data, rx_valid, rx_parity_err,
         rx_frame_err, busy} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: got chk=%h ev=%b fi=%b data=%h v=%b pe=%b fe=%b busy=%b, expected all 0",
               chk_data, chk_even_parity, chk_fault_inject, rx_data, rx_valid, rx_parity_err,
               rx_frame_err, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_even();
    cfg_parity_en = 1'b1;
    cfg_even_parity = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v0, obs_v1, obs_v2} !== 3'b010) begin
      n_fails++;
      $display("FAIL good_valid_timing: got %b, expected 010", {obs_v0, obs_v1, obs_v2});
    end
    n_checks++;
    if (obs_data !== 8'hA5) begin
      n_fails++; $display("FAIL good_data: got %h, expected a5", obs_data);
    end
    n_checks++;
    if ({obs_perr, obs_ferr} !== 2'b00) begin
      n_fails++; $display("FAIL good_status: got %b, expected 00", {obs_perr, obs_ferr});
    end
    n_checks++;
    if (obs_chk !== 9'h0A5) begin
      n_fails++; $display("FAIL good_chk_data: got %h, expected 0a5", obs_chk);
    end
    n_checks++;
    if ({chk_even_parity, busy} !== 2'b10) begin
      n_fails++;
      $display("FAIL good_even_busy: got %b, expected 10", {chk_even_parity, busy});
    end
  endtask

  task automatic test_bad_parity();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr, obs_ferr} !== 3'b110) begin
      n_fails++;
      $display("FAIL bad_parity: got v/pe/fe=%b, expected 110", {obs_v1, obs_perr, obs_ferr});
    end
    n_checks++;
    if (obs_chk !== 9'h1A5) begin
      n_fails++; $display("FAIL bad_parity_chk_data: got %h, expected 1a5", obs_chk);
    end
    cfg_even_parity = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr, obs_data} !== {2'b10, 8'h01}) begin
      n_fails++;
      $display("FAIL odd_parity_ok: got v=%b pe=%b data=%h, expected v=1 pe=0 data=01",
               obs_v1, obs_perr, obs_data);
    end
    n_checks++;
    if (chk_even_parity !== 1'b0) begin
      n_fails++; $display("FAIL odd_cfg_latched: got %b, expected 0", chk_even_parity);
    end
    cfg_even_parity = 1'b1;
  endtask

  task automatic test_fault_inject();
    pulse_inject();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr} !== 2'b11) begin
      n_fails++; $display("FAIL fault_perr: got v/pe=%b, expected 11", {obs_v1, obs_perr});
    end
    n_checks++;
    if ({obs_fi0, obs_fi1} !== 2'b10) begin
      n_fails++; $display("FAIL fault_pulse: got %b, expected 10", {obs_fi0, obs_fi1});
    end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr, obs_fi0} !== 3'b100) begin
      n_fails++;
      $display("FAIL fault_consumed: got v/pe/fi=%b, expected 100", {obs_v1, obs_perr, obs_fi0});
    end
  endtask

  task automatic test_fault_parity_off();
    pulse_inject();
    cfg_parity_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr, obs_fi0, obs_data} !== {3'b100, 8'h55}) begin
      n_fails++;
      $display("FAIL noparity_frame: got v=%b pe=%b fi=%b data=%h, expected 1 0 0 55",
               obs_v1, obs_perr, obs_fi0, obs_data);
    end
    n_checks++;
    if (obs_chk !== 9'h055) begin
      n_fails++; $display("FAIL noparity_chk_data: got %h, expected 055", obs_chk);
    end
    cfg_parity_en = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr, obs_fi0} !== 3'b111) begin
      n_fails++;
      $display("FAIL arm_survives: got v/pe/fi=%b, expected 111", {obs_v1, obs_perr, obs_fi0});
    end
  endtask

  task automatic test_glitch();
    int p;
    p = valid_pulses;
    repeat (4) tick_rx(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++; $display("FAIL glitch_start_busy: got %b, expected 1", busy);
    end
    repeat (8) tick_rx(1'b1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++; $display("FAIL glitch_back_idle: got %b, expected 0", busy);
    end
    n_checks++;
    if (valid_pulses !== p) begin
      n_fails++; $display("FAIL glitch_no_valid: got %0d pulses, expected %0d", valid_pulses, p);
    end
  endtask

  task automatic test_frame_err();
    int p;
    cfg_parity_en = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({obs_v1, obs_ferr, obs_perr, obs_data} !== {3'b110, 8'h5A}) begin
      n_fails++;
      $display("FAIL frame_err: got v=%b fe=%b pe=%b data=%h, expected 1 1 0 5a",
               obs_v1, obs_ferr, obs_perr, obs_data);
    end
    p = valid_pulses;
    repeat (40) tick_rx(1'b0);
    n_checks++;
    if (busy !== 1'b0 || valid_pulses !== p) begin
      n_fails++;
      $display("FAIL break_hold: got busy=%b pulses=%0d, expected busy=0 pulses=%0d",
               busy, valid_pulses, p);
    end
    tick_rx(1'b1);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_ferr, obs_data} !== {2'b10, 8'h11}) begin
      n_fails++;
      $display("FAIL after_break: got v=%b fe=%b data=%h, expected 1 0 11",
               obs_v1, obs_ferr, obs_data);
    end
    cfg_parity_en = 1'b1;
  endtask

  task automatic test_reset_mid_data();
    int p;
    pulse_inject();
    p = valid_pulses;
    for (int k = 0; k < 60; k++) tick_rx(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++; $display("FAIL middata_busy: got %b, expected 1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({chk_data, chk_even_parity, chk_fault_inject, rx_data, rx_valid, rx_parity_err,
         rx_frame_err, busy} !== '0) begin
      n_fails++;
      $display("FAIL middata_reset_outputs: got chk=%h ev=%b data=%h v=%b pe=%b fe=%b busy=%b, expected all 0",
               chk_data, chk_even_parity, rx_data, rx_valid, rx_parity_err, rx_frame_err, busy);
    end
    repeat (20) tick_rx(1'b1);
    n_checks++;
    if (valid_pulses !== p) begin
      n_fails++;
      $display("FAIL middata_no_valid: got %0d pulses, expected %0d", valid_pulses, p);
    end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({obs_v1, obs_perr, obs_ferr, obs_fi0, obs_data} !== {4'b1000, 8'hFF}) begin
      n_fails++;
      $display("FAIL after_reset_frame: got v=%b pe=%b fe=%b fi=%b data=%h, expected 1 0 0 0 ff",
               obs_v1, obs_perr, obs_ferr, obs_fi0, obs_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    baud_tick = 1'b0;
    rx = 1'b1;
    cfg_parity_en = 1'b0;
    cfg_even_parity = 1'b0;
    inject_parity_fault = 1'b0;
    test_reset();
    test_good_even();
    test_bad_parity();
    test_fault_inject();
    test_fault_parity_off();
    test_glitch();
    test_frame_err();
    test_reset_mid_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
